// File: rtl/filter_mul_arbiter.sv
// filter_mul_arbiter: NUM_REQ filter-tap requesters share one pipelined signed x unsigned multiplier.
// Build option FILTER_MUL_ARB_RR_EN selects round-robin grants; without it the lowest index wins.

module filter_mul_arbiter_lane #(
   parameter int W = 30
) (
   input  logic         ap_clk,
   input  logic         ap_rst,
   input  logic         req_valid,
   input  logic         grant,
   input  logic         load,
   input  logic         rsp_ready,
   input  logic [W-1:0] p,
   output logic         elig,
   output logic         outst,
   output logic         rsp_valid,
   output logic [W-1:0] rsp_dout
);
   assign elig = req_valid & ~outst;

   // outst blocks a second issue, so load never meets a busy response register
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         outst     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_dout  <= '0;
      end else begin
         if (grant)
            outst <= 1'b1;
         else if (rsp_valid & rsp_ready)
            outst <= 1'b0;
         if (load) begin
            rsp_valid <= 1'b1;
            rsp_dout  <= p;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule

module filter_mul_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 24,
   parameter int din1_WIDTH = 6,
   parameter int dout_WIDTH = 30
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*din0_WIDTH-1:0]   req_din0,
   input  logic [NUM_REQ*din1_WIDTH-1:0]   req_din1,
   output logic [NUM_REQ-1:0]              rsp_valid,
   input  logic [NUM_REQ-1:0]              rsp_ready,
   output logic [NUM_REQ*dout_WIDTH-1:0]   rsp_dout,
   output logic                            busy
);
   localparam int IDW = $clog2(NUM_REQ);

   typedef struct packed {
      logic [IDW-1:0]        id;
      logic [dout_WIDTH-1:0] p;
   } stage_t;

   logic [NUM_REQ-1:0][din0_WIDTH-1:0] din0_a;
   logic [NUM_REQ-1:0][din1_WIDTH-1:0] din1_a;
   logic [NUM_REQ-1:0][dout_WIDTH-1:0] dout_a;
   logic [NUM_REQ-1:0]                 elig, outst;
   logic [IDW-1:0]                     gnt_id;
   logic                               gnt_any;
   logic signed [dout_WIDTH-1:0]       a_ext, b_ext, prod;
   logic                               fin_vld, busy_pipe;
   stage_t                             fin;

   assign din0_a = req_din0;
   assign din1_a = req_din1;

`ifdef FILTER_MUL_ARB_RR_EN
   logic [IDW-1:0] ptr;

   // scan from the highest offset down so the first eligible slot after ptr wins
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (elig[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst)
         ptr <= '0;
      else if (gnt_any)
         ptr <= (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + 1'b1;
   end
`else
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (elig[k]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(k);
         end
      end
   end
`endif

   always_comb begin
      req_ready = '0;
      if (gnt_any) req_ready[gnt_id] = 1'b1;
   end

   // both operands widened to the product width so the signed multiply is exact
   assign a_ext = {{din1_WIDTH{din0_a[gnt_id][din0_WIDTH-1]}}, din0_a[gnt_id]};
   assign b_ext = {{din0_WIDTH{1'b0}}, din1_a[gnt_id]};
   assign prod  = a_ext * b_ext;

   generate
      if (NUM_STAGE == 1) begin : g_direct
         assign fin_vld   = gnt_any;
         assign fin.id    = gnt_id;
         assign fin.p     = prod;
         assign busy_pipe = 1'b0;
      end else begin : g_pipe
         logic [NUM_STAGE-1:1] vld_pipe;
         stage_t               pl_pipe [NUM_STAGE-1:1];

         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               vld_pipe <= '0;
            end else begin
               vld_pipe[1] <= gnt_any;
               for (int k = 2; k < NUM_STAGE; k++) vld_pipe[k] <= vld_pipe[k-1];
            end
            pl_pipe[1] <= '{id: gnt_id, p: prod};
            for (int k = 2; k < NUM_STAGE; k++) pl_pipe[k] <= pl_pipe[k-1];
         end

         assign fin_vld   = vld_pipe[NUM_STAGE-1];
         assign fin       = pl_pipe[NUM_STAGE-1];
         assign busy_pipe = |vld_pipe;
      end

      for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
         filter_mul_arbiter_lane #(.W(dout_WIDTH)) u_lane (
            .ap_clk    (ap_clk),
            .ap_rst    (ap_rst),
            .req_valid (req_valid[i]),
            .grant     (req_ready[i]),
            .load      (fin_vld && (fin.id == IDW'(i))),
            .rsp_ready (rsp_ready[i]),
            .p         (fin.p),
            .elig      (elig[i]),
            .outst     (outst[i]),
            .rsp_valid (rsp_valid[i]),
            .rsp_dout  (dout_a[i])
         );
      end
   endgenerate

   assign rsp_dout = dout_a;
   assign busy     = busy_pipe | (|outst);
endmodule

// File: tb/tb_filter_mul_arbiter.sv
// Bench for filter_mul_arbiter: vector table, corner sequences and random traffic vs a transaction model.
// Honours FILTER_MUL_ARB_RR_EN the same way as the design.

module tb_filter_mul_arbiter;
   localparam int N  = 4;
   localparam int NS = 2;
   localparam int W0 = 24;
   localparam int W1 = 6;
   localparam int WO = 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]         tv, trr, req_ready, rsp_valid;
   logic [N-1:0][W0-1:0] td0;
   logic [N-1:0][W1-1:0] td1;
   logic [N-1:0][WO-1:0] rsp_dout;
   logic                 busy;

   filter_mul_arbiter #(.NUM_REQ(N), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)) dut (
      .ap_clk    (clk),
      .ap_rst    (rst),
      .req_valid (tv),
      .req_ready (req_ready),
      .req_din0  (td0),
      .req_din1  (td1),
      .rsp_valid (rsp_valid),
      .rsp_ready (trr),
      .rsp_dout  (rsp_dout),
      .busy      (busy)
   );

   int errors = 0;
   int checks = 0;

   // transaction model: outstanding set, delivered responses, in-flight list with remaining edges
   typedef struct {
      int            id;
      logic [WO-1:0] p;
      int            rem;
   } fl_t;
   typedef struct {
      int            id;
      logic [W0-1:0] a;
      logic [W1-1:0] b;
      logic [WO-1:0] exp;
   } vec_t;

   bit            m_out [N];
   bit            m_rv  [N];
   logic [WO-1:0] m_rd  [N];
   int            m_ptr;
   fl_t           fl [$];
   int            last_g;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [WO-1:0] mulref(input logic [W0-1:0] a, input logic [W1-1:0] b);
      longint r;
      r = longint'($signed(a)) * longint'(b);
      return r[WO-1:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_out[i] = 1'b0;
         m_rv[i]  = 1'b0;
         m_rd[i]  = '0;
      end
      m_ptr = 0;
      fl.delete();
      last_g = -1;
   endtask

   // inputs are set by the caller; compare, take one edge, advance the model
   task automatic step();
      int                   g;
      logic [N-1:0]         er, ev;
      logic [N-1:0][WO-1:0] ed;
      logic                 eb;
      logic [WO-1:0]        p;
      g  = -1;
      eb = 1'b0;
      #1;
      for (int k = 0; k < N; k++) begin
         int idx;
`ifdef FILTER_MUL_ARB_RR_EN
         idx = (m_ptr + k) % N;
`else
         idx = k;
`endif
         if (g < 0 && tv[idx] && !m_out[idx]) g = idx;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      for (int i = 0; i < N; i++) begin
         ev[i] = m_rv[i];
         ed[i] = m_rd[i];
         eb    = eb | m_out[i];
      end
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, ev);
      chk("rsp_dout", rsp_dout, ed);
      chk("busy", busy, eb);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < N; i++)
            if (m_rv[i] && trr[i]) begin
               m_rv[i]  = 1'b0;
               m_out[i] = 1'b0;
            end
         foreach (fl[j]) fl[j].rem--;
         while (fl.size() > 0 && fl[0].rem == 0) begin
            m_rv[fl[0].id] = 1'b1;
            m_rd[fl[0].id] = fl[0].p;
            void'(fl.pop_front());
         end
         last_g = g;
         if (g >= 0) begin
            m_out[g] = 1'b1;
            m_ptr    = (g + 1) % N;
            p        = mulref(td0[g], td1[g]);
            if (NS == 1) begin
               m_rv[g] = 1'b1;
               m_rd[g] = p;
            end else begin
               fl.push_back('{id: g, p: p, rem: NS-1});
            end
         end
      end
      #1;
   endtask

   vec_t tbl [7];
   int   seq [$];
   int   exps [5];
   int   id, n;

   initial begin
      tv  = '0;
      trr = '1;
      td0 = '0;
      td1 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      step();
      rst = 1'b0;

      tbl[0] = '{0, W0'(-8388608), 6'd63, WO'(-528482304)};
      tbl[1] = '{1, W0'(8388607),  6'd63, WO'(528482241)};
      tbl[2] = '{2, W0'(5),        6'd0,  WO'(0)};
      tbl[3] = '{3, W0'(-1),       6'd1,  WO'(-1)};
      tbl[4] = '{0, W0'(0),        6'd63, WO'(0)};
      tbl[5] = '{1, W0'(1000),     6'd7,  WO'(7000)};
      tbl[6] = '{3, W0'(-1000),    6'd3,  WO'(-3000)};

      foreach (tbl[t]) begin
         id      = tbl[t].id;
         td0[id] = tbl[t].a;
         td1[id] = tbl[t].b;
         tv      = '0;
         tv[id]  = 1'b1;
         trr     = '1;
         n = 0;
         do begin step(); n++; end while (last_g != id && n < 10);
         chk("tbl_issue", last_g, id);
         tv = '0;
         n  = 0;
         while (!rsp_valid[id] && n < 10) begin step(); n++; end
         chk("tbl_latency", n, NS-1);
         chk("tbl_dout", rsp_dout[id], tbl[t].exp);
         step();
         step();
      end

      // everyone requests; grant order depends on the arbitration mode
      for (int i = 0; i < N; i++) begin
         td0[i] = W0'(1000 * (i + 1));
         td1[i] = 6'd1;
      end
      tv = '1;
      trr = '1;
      seq.delete();
      repeat (12) begin
         step();
         if (last_g >= 0) seq.push_back(last_g);
      end
      tv = '0;
      repeat (4) step();
`ifdef FILTER_MUL_ARB_RR_EN
      exps = '{0, 1, 2, 3, 0};
`else
      exps = '{0, 1, 2, 0, 1};
`endif
      for (int k = 0; k < 5; k++) chk("grant_order", (seq.size() > k) ? seq[k] : -1, exps[k]);

      // backpressure on requester 1 while the others keep issuing
      td0[1] = W0'(8388607);
      td1[1] = 6'd63;
      tv = 4'b0010;
      n = 0;
      do begin step(); n++; end while (last_g != 1 && n < 10);
      chk("bp_issue", last_g, 1);
      tv  = 4'b1101;
      trr = 4'b1101;
      n = 0;
      repeat (10) begin
         step();
         if (last_g >= 0 && last_g != 1) n++;
         chk("bp_valid", rsp_valid[1], 1'b1);
         chk("bp_dout", rsp_dout[1], WO'(528482241));
         chk("bp_ready", req_ready[1], 1'b0);
      end
      chk("bp_others_granted", n > 3, 1'b1);
      tv  = '0;
      trr = '1;
      repeat (6) step();

      // reset one cycle after a grant flushes the operation
      td0[0] = W0'(77);
      td1[0] = 6'd5;
      tv = 4'b0001;
      n = 0;
      do begin step(); n++; end while (last_g != 0 && n < 10);
      chk("rst_issue", last_g, 0);
      tv  = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_rsp_dout", rsp_dout, '0);
      chk("rst_req_ready", req_ready, '0);
      n = 0;
      repeat (5) begin
         step();
         if (rsp_valid != '0) n++;
      end
      chk("rst_flush", n, 0);

      repeat (3000) begin
         tv  = N'($urandom);
         trr = N'($urandom);
         for (int i = 0; i < N; i++) begin
            td0[i] = W0'($urandom);
            td1[i] = W1'($urandom);
         end
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      tv  = '0;
      trr = '1;
      repeat (6) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
